// File: rtl/pipeline_ctrl_if.sv
// Pipeline-to-controller bundle: cache handshakes, hazard inputs,
// register enables, bubble/flush controls and the performance counters.
interface pipeline_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 imem_read;
  logic                 imem_resp;
  logic                 dmem_req;
  logic                 dmem_resp;
  logic                 load_use;
  logic                 mispredict;

  logic                 imem_read_out;
  logic                 dmem_req_out;
  logic                 load_pc;
  logic                 load_if_id;
  logic                 load_id_ex;
  logic                 load_ex_mem;
  logic                 load_mem_wb;
  logic                 bubble_id_ex;
  logic                 flush_if_id;
  logic                 flush_id_ex;
  logic                 flush_ex_mem;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;
  // Stall state for tracing: 0=RUN, 1=WAIT_I, 2=WAIT_D, 3=WAIT_BOTH
  logic [1:0]           ctrl_state;

  // Pipeline/datapath side: raises requests and hazards, consumes controls
  modport master (
    output imem_read, imem_resp, dmem_req, dmem_resp, load_use, mispredict,
    input  imem_read_out, dmem_req_out, load_pc, load_if_id, load_id_ex,
           load_ex_mem, load_mem_wb, bubble_id_ex, flush_if_id, flush_id_ex,
           flush_ex_mem, stall_count, flush_count, ctrl_state
  );

  // Controller side
  modport slave (
    input  imem_read, imem_resp, dmem_req, dmem_resp, load_use, mispredict,
    output imem_read_out, dmem_req_out, load_pc, load_if_id, load_id_ex,
           load_ex_mem, load_mem_wb, bubble_id_ex, flush_if_id, flush_id_ex,
           flush_ex_mem, stall_count, flush_count, ctrl_state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. A cache response that
// arrives while the other cache is still busy is remembered in a done flag,
// so the request is masked off (never reissued) and the response is not lost.
module pipeline_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_I    = 2'd1,
    WAIT_D    = 2'd2,
    WAIT_BOTH = 2'd3
  } state_t;

  state_t               state;
  state_t               next_state;
  logic                 i_done;
  logic                 d_done;
  logic                 i_ready;
  logic                 d_ready;
  logic                 advance;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  // State, remembered responses and saturating counters; done flags clear whenever the pipe advances
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= next_state;
      i_done <= advance ? 1'b0 : (i_done | (bus.imem_read & bus.imem_resp));
      d_done <= advance ? 1'b0 : (d_done | (bus.dmem_req & bus.dmem_resp));
      if (!advance && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (advance && bus.mispredict && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Readiness, next stall state and pipeline controls; hazards only act on an advancing cycle
  always_comb begin
    i_ready = !bus.imem_read | bus.imem_resp | i_done;
    d_ready = !bus.dmem_req | bus.dmem_resp | d_done;
    advance = i_ready & d_ready;

    bus.imem_read_out = bus.imem_read & !i_done;
    bus.dmem_req_out  = bus.dmem_req & !d_done;

    bus.load_pc      = 1'b0;
    bus.load_if_id   = 1'b0;
    bus.load_id_ex   = 1'b0;
    bus.load_ex_mem  = 1'b0;
    bus.load_mem_wb  = 1'b0;
    bus.bubble_id_ex = 1'b0;
    bus.flush_if_id  = 1'b0;
    bus.flush_id_ex  = 1'b0;
    bus.flush_ex_mem = 1'b0;
    next_state       = RUN;

    if (advance) begin
      bus.load_id_ex  = 1'b1;
      bus.load_ex_mem = 1'b1;
      bus.load_mem_wb = 1'b1;
      if (bus.mispredict) begin
        bus.load_pc      = 1'b1;
        bus.load_if_id   = 1'b1;
        bus.flush_if_id  = 1'b1;
        bus.flush_id_ex  = 1'b1;
        bus.flush_ex_mem = 1'b1;
      end else if (bus.load_use) begin
        bus.bubble_id_ex = 1'b1;
      end else begin
        bus.load_pc    = 1'b1;
        bus.load_if_id = 1'b1;
      end
    end else if (!i_ready && !d_ready) begin
      next_state = WAIT_BOTH;
    end else if (!i_ready) begin
      next_state = WAIT_I;
    end else begin
      next_state = WAIT_D;
    end
  end

  assign bus.stall_count = stall_cnt;
  assign bus.flush_count = flush_cnt;
  assign bus.ctrl_state  = state;

endmodule
